// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg
// Shared constants and types for the instruction-cache boot loader.
//   ICACHE_ADDR_WIDTH : word-address width of the cache SDPRAM (1024 words)
//   ICACHE_DATA_WIDTH : cache RAM word width
//   ICACHE_BYTE_SIZE  : width of one byte on the incoming boot stream
//   LANES             : number of stream bytes packed into one RAM word
//   icache_state_e    : loader FSM states
// ----------------------------------------------------------------------------
package icache_pkg;

    localparam int ICACHE_ADDR_WIDTH = 10;
    localparam int ICACHE_DATA_WIDTH = 32;
    localparam int ICACHE_BYTE_SIZE  = 8;
    localparam int LANES             = ICACHE_DATA_WIDTH / ICACHE_BYTE_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_byte_packer.sv
// ----------------------------------------------------------------------------
// icache_byte_packer
// Collects stream bytes little-endian into a RAM word and emits a one-cycle
// word_valid pulse, together with the packed word, the cycle after the byte
// that fills the last lane is accepted.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   clear_i      : restart packing at lane 0 (new load or abort)
//   byte_fire_i  : a byte is accepted this cycle
//   byte_data_i  : the accepted byte
//   last_lane_o  : the next accepted byte completes a word
//   word_valid_o : registered one-cycle pulse, word_data_o holds a new word
//   word_data_o  : packed word, holds its value between pulses
// ----------------------------------------------------------------------------
module icache_byte_packer
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
    parameter int BYTE_SIZE  = ICACHE_BYTE_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  byte_fire_i,
    input  logic [BYTE_SIZE-1:0]  byte_data_i,
    output logic                  last_lane_o,
    output logic                  word_valid_o,
    output logic [DATA_WIDTH-1:0] word_data_o
);

    localparam int LANE_COUNT = DATA_WIDTH / BYTE_SIZE;
    localparam int LANE_W     = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANE_COUNT - 1);

    logic [LANE_W-1:0]     lane_q;
    logic [DATA_WIDTH-1:0] pack_q;
    logic [DATA_WIDTH-1:0] pack_d;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  valid_q;

    assign last_lane_o  = (lane_q == LAST_LANE);
    assign word_valid_o = valid_q;
    assign word_data_o  = word_q;

    // Drop the incoming byte into its lane. The completed word is taken from
    // pack_d so the final byte lands in the word the same cycle it arrives.
    always_comb begin
        pack_d = pack_q;
        pack_d[lane_q*BYTE_SIZE +: BYTE_SIZE] = byte_data_i;
    end

    // Lane counter wraps after the last lane; word_q only changes when a
    // word completes so the RAM write data holds between strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q  <= '0;
            pack_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear_i) begin
                lane_q <= '0;
            end else if (byte_fire_i) begin
                pack_q <= pack_d;
                if (last_lane_o) begin
                    lane_q  <= '0;
                    word_q  <= pack_d;
                    valid_q <= 1'b1;
                end else begin
                    lane_q <= lane_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/icache_loader.sv
// ----------------------------------------------------------------------------
// icache_loader
// Fills the instruction-cache SDPRAM from a byte stream. Bytes are packed
// little-endian into words which are written to consecutive addresses from
// a programmed base, while a running modular word checksum is kept.
// Ports:
//   wr_clk, wr_rst        : clock and synchronous active-high reset
//   start, abort          : begin a load (IDLE only) / cancel a load
//   base_addr, word_count : first word address and number of words
//   s_valid/s_data/s_ready: byte stream handshake
//   wr_en/wr_addr/wr_data : registered RAM write port
//   busy, done, checksum  : status for the boot controller
// ----------------------------------------------------------------------------
module icache_loader
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
    parameter int BYTE_SIZE  = ICACHE_BYTE_SIZE
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  s_valid,
    input  logic [BYTE_SIZE-1:0]  s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    icache_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic                  final_q, final_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    logic byte_fire;
    logic last_lane;
    logic word_done;
    logic packer_clear;

    // final_q marks that the last word's byte has been taken: the stream is
    // closed immediately so no byte beyond the final word is consumed.
    assign s_ready      = (state_q == LOAD) && !final_q;
    assign byte_fire    = s_valid && s_ready && !abort;
    assign word_done    = byte_fire && last_lane;
    assign packer_clear = ((state_q == IDLE) && start) || ((state_q == LOAD) && abort);

    assign busy     = (state_q == LOAD);
    assign done     = (state_q == DONE);
    assign wr_addr  = wr_addr_q;
    assign checksum = checksum_q;

    icache_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_SIZE  (BYTE_SIZE)
    ) u_packer (
        .clk_i        (wr_clk),
        .rst_i        (wr_rst),
        .clear_i      (packer_clear),
        .byte_fire_i  (byte_fire),
        .byte_data_i  (s_data),
        .last_lane_o  (last_lane),
        .word_valid_o (wr_en),
        .word_data_o  (wr_data)
    );

    // Next-state logic. The write address is captured when a word completes,
    // so it lines up with the packer's registered word on the wr_en cycle.
    // The checksum accumulates on the wr_en cycle itself, and the FSM leaves
    // LOAD on the cycle the final word is strobed.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        final_d    = final_q;
        wr_addr_d  = wr_addr_q;
        checksum_d = checksum_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    checksum_d = '0;
                    final_d    = 1'b0;
                    if (word_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOAD;
                        addr_d   = base_addr;
                        remain_d = word_count;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    final_d = 1'b0;
                end else begin
                    if (word_done) begin
                        wr_addr_d = addr_q;
                        addr_d    = addr_q + 1'b1;
                        remain_d  = remain_q - 1'b1;
                        if (remain_q == (ADDR_WIDTH+1)'(1)) begin
                            final_d = 1'b1;
                        end
                    end
                    if (wr_en) begin
                        checksum_d = checksum_q + wr_data;
                    end
                    if (final_q) begin
                        state_d = DONE;
                        final_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            final_q    <= 1'b0;
            wr_addr_q  <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            final_q    <= final_d;
            wr_addr_q  <= wr_addr_d;
            checksum_q <= checksum_d;
        end
    end

endmodule

// File: tb/tb_icache_loader.sv
// ----------------------------------------------------------------------------
// tb_icache_loader
// Self-checking bench for icache_loader: a table of per-cycle vectors for
// the basic load, plus hand-written sequences for gaps/wrap, abort, edge
// commands, reset mid-load and a full 1024-word fill read back from a model
// of the cache RAM.
// ----------------------------------------------------------------------------
module tb_icache_loader;

    logic        wr_clk;
    logic        wr_rst;
    logic        start;
    logic        abort;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    int checks;
    int failures;

    typedef struct {
        logic        start;
        logic        abort;
        logic [9:0]  base;
        logic [10:0] cnt;
        logic        sValid;
        logic [7:0]  sData;
        logic        expWrEn;
        logic        expReady;
        logic        expBusy;
        logic        expDone;
        logic [9:0]  expAddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] ram [0:1023];
    int          capAddr[$];
    logic [31:0] capData[$];
    int          doneCount;

    icache_loader dut (
        .wr_clk     (wr_clk),
        .wr_rst     (wr_rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    // 100 MHz clock
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    // Monitor: samples the write port and done on the falling edge, acting
    // as the cache RAM and as a log of every write and done pulse.
    initial doneCount = 0;
    always @(negedge wr_clk) begin
        if (wr_en === 1'b1) begin
            capAddr.push_back(int'(wr_addr));
            capData.push_back(wr_data);
            ram[wr_addr] = wr_data;
        end
        if (done === 1'b1) doneCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic logic [31:0] capAddrAt(input int i);
        if (i < capAddr.size()) return 32'(capAddr[i]);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] capDataAt(input int i);
        if (i < capData.size()) return capData[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic addVec(input logic st, input logic [9:0] base, input logic [10:0] cnt,
                          input logic sv, input logic [7:0] sd, input logic eWr,
                          input logic eRdy, input logic eBusy, input logic eDone,
                          input logic [9:0] eAddr, input logic [31:0] eData);
        vec_t v;
        v.start = st; v.abort = 1'b0; v.base = base; v.cnt = cnt;
        v.sValid = sv; v.sData = sd; v.expWrEn = eWr; v.expReady = eRdy;
        v.expBusy = eBusy; v.expDone = eDone; v.expAddr = eAddr; v.expData = eData;
        vecs.push_back(v);
    endtask

    // Drive one vector for one clock and compare right after the edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        start      = v.start;
        abort      = v.abort;
        base_addr  = v.base;
        word_count = v.cnt;
        s_valid    = v.sValid;
        s_data     = v.sData;
        @(posedge wr_clk); #1;
        checkOutput($sformatf("vec%0d_wr_en", idx), 32'(wr_en), 32'(v.expWrEn));
        checkOutput($sformatf("vec%0d_s_ready", idx), 32'(s_ready), 32'(v.expReady));
        checkOutput($sformatf("vec%0d_busy", idx), 32'(busy), 32'(v.expBusy));
        checkOutput($sformatf("vec%0d_done", idx), 32'(done), 32'(v.expDone));
        checkOutput($sformatf("vec%0d_wr_addr", idx), 32'(wr_addr), 32'(v.expAddr));
        checkOutput($sformatf("vec%0d_wr_data", idx), wr_data, v.expData);
    endtask

    task automatic startLoad(input logic [9:0] base, input logic [10:0] cnt);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        @(posedge wr_clk); #1;
        start = 1'b0;
    endtask

    // Hold a byte until the DUT accepts it; s_ready is read on the falling
    // edge so the following rising edge is known to complete the handshake.
    task automatic sendByte(input logic [7:0] d, input string name);
        bit accepted;
        accepted = 0;
        s_valid  = 1'b1;
        s_data   = d;
        for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge wr_clk);
            if (s_ready === 1'b1) accepted = 1;
            @(posedge wr_clk); #1;
        end
        if (!accepted) timeoutFail(name);
    endtask

    task automatic waitDone(input string name, input int budget);
        bit got;
        got = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge wr_clk);
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) timeoutFail(name);
        @(posedge wr_clk); #1;
    endtask

    initial begin
        logic [31:0] basicSum;
        logic [31:0] word;
        logic [31:0] fillSum;
        logic [9:0]  heldAddr;
        logic [31:0] heldData;
        int          capBase;
        int          doneBase;
        int          bad;

        checks = 0;
        failures = 0;
        wr_rst = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; word_count = '0; s_valid = 1'b1; s_data = 8'hA5;

        // ---- Reset held for 5 cycles with a valid stream ----
        repeat (5) @(posedge wr_clk);
        #1;
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_checksum", checksum, 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        wr_rst = 1'b0;
        s_valid = 1'b0;
        @(posedge wr_clk); #1;

        // ---- Basic load as a vector table; a start pulsed at byte 5 with a
        //      different base/count must be ignored ----
        basicSum = '0;
        heldAddr = '0;
        heldData = '0;
        addVec(1'b1, 10'h000, 11'd4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, heldAddr, heldData);
        for (int k = 0; k < 16; k++) begin
            logic wrNow;
            wrNow = (k % 4 == 3);
            if (wrNow) begin
                heldAddr = 10'(k / 4);
                heldData = {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)};
                basicSum = basicSum + heldData;
            end
            addVec(k == 5, (k == 5) ? 10'h155 : 10'h000, (k == 5) ? 11'd2 : 11'd4,
                   1'b1, 8'(k), wrNow, k != 15, 1'b1, 1'b0, heldAddr, heldData);
        end
        addVec(1'b0, 10'h000, 11'd4, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, heldAddr, heldData);
        addVec(1'b0, 10'h000, 11'd4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, heldAddr, heldData);
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);
        checkOutput("basic_checksum", checksum, basicSum);

        // ---- Gaps and address wrap ----
        capBase = capAddr.size();
        doneBase = doneCount;
        startLoad(10'h3FE, 11'd4);
        for (int k = 0; k < 16; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                s_valid = 1'b0;
                repeat (gap) @(posedge wr_clk);
                #1;
            end
            sendByte(8'(k), "gap_byte");
        end
        s_valid = 1'b0;
        waitDone("gap_done_wait", 10);
        checkOutput("gap_write_count", 32'(capAddr.size() - capBase), 32'd4);
        for (int w = 0; w < 4; w++) begin
            checkOutput($sformatf("gap_addr%0d", w), capAddrAt(capBase + w), 32'((10'h3FE + 10'(w)) & 10'h3FF));
            checkOutput($sformatf("gap_data%0d", w), capDataAt(capBase + w),
                        {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        end
        checkOutput("gap_done_count", 32'(doneCount - doneBase), 32'd1);
        checkOutput("gap_checksum", checksum, basicSum);

        // ---- Abort after 6 bytes, then a fresh one-word load ----
        capBase = capAddr.size();
        doneBase = doneCount;
        startLoad(10'h010, 11'd4);
        for (int k = 0; k < 6; k++) sendByte(8'(k), "abort_byte");
        s_valid = 1'b1; s_data = 8'h06; abort = 1'b1;
        @(posedge wr_clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_s_ready", 32'(s_ready), 32'd0);
        repeat (3) @(posedge wr_clk);
        #1;
        checkOutput("abort_write_count", 32'(capAddr.size() - capBase), 32'd1);
        checkOutput("abort_addr", capAddrAt(capBase), 32'h010);
        checkOutput("abort_data", capDataAt(capBase), 32'h03020100);
        checkOutput("abort_no_done", 32'(doneCount - doneBase), 32'd0);
        startLoad(10'h020, 11'd1);
        for (int k = 0; k < 4; k++) sendByte(8'hA0 + 8'(k), "reload_byte");
        s_valid = 1'b0;
        waitDone("reload_done_wait", 10);
        checkOutput("reload_write_count", 32'(capAddr.size() - capBase), 32'd2);
        checkOutput("reload_addr", capAddrAt(capBase + 1), 32'h020);
        checkOutput("reload_data", capDataAt(capBase + 1), 32'hA3A2A1A0);

        // ---- Abort coinciding with the final-lane handshake ----
        capBase = capAddr.size();
        startLoad(10'h030, 11'd2);
        for (int k = 0; k < 3; k++) sendByte(8'h11 * 8'(k + 1), "abortlast_byte");
        s_valid = 1'b1; s_data = 8'h44; abort = 1'b1;
        @(posedge wr_clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        checkOutput("abortlast_write_count", 32'(capAddr.size() - capBase), 32'd0);

        // ---- word_count = 0 ----
        capBase = capAddr.size();
        doneBase = doneCount;
        startLoad(10'h077, 11'd0);
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_busy", 32'(busy), 32'd0);
        checkOutput("zero_checksum", checksum, 32'd0);
        @(posedge wr_clk); #1;
        checkOutput("zero_done_fall", 32'(done), 32'd0);
        checkOutput("zero_write_count", 32'(capAddr.size() - capBase), 32'd0);

        // ---- Reset in the middle of a load, on the final-lane byte ----
        capBase = capAddr.size();
        startLoad(10'h040, 11'd2);
        for (int k = 0; k < 3; k++) sendByte(8'h51 + 8'(k), "rstmid_byte");
        s_valid = 1'b1; s_data = 8'h54; wr_rst = 1'b1;
        @(posedge wr_clk); #1;
        checkOutput("rstmid_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rstmid_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        wr_rst = 1'b0; s_valid = 1'b0;
        repeat (4) @(posedge wr_clk);
        #1;
        checkOutput("rstmid_write_count", 32'(capAddr.size() - capBase), 32'd0);

        // ---- Full 1024-word fill with a decrementing pattern ----
        capBase = capAddr.size();
        doneBase = doneCount;
        fillSum = '0;
        startLoad(10'h000, 11'd1024);
        for (int i = 0; i < 1024; i++) begin
            word = 32'hFFFF_FFFF - 32'(i);
            fillSum = fillSum + word;
            for (int b = 0; b < 4; b++) sendByte(word[8*b +: 8], "fill_byte");
        end
        s_valid = 1'b0;
        waitDone("fill_done_wait", 10);
        checkOutput("fill_write_count", 32'(capAddr.size() - capBase), 32'd1024);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            word = 32'hFFFF_FFFF - 32'(i);
            if (ram[i] !== word) bad++;
        end
        checkOutput("fill_ram_bad_words", 32'(bad), 32'd0);
        checkOutput("fill_checksum", checksum, fillSum);
        checkOutput("fill_done_count", 32'(doneCount - doneBase), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
